// File: rtl/digpot_ctrl.sv
// Up/down digital potentiometer controller: clamps and converts a requested
// wiper position into a direction + pulse count burst, with setup/hold framing.
module digpot_ctrl #(
  parameter int MAX_POS       = 99,
  parameter int SETUP_CYC     = 4,
  parameter int HOLD_CYC      = 8,
  parameter int TIMEOUT       = 4096,
  parameter int HOME_ON_RESET = 1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [6:0] wr_target,
  input  logic       store_req,
  output logic       wr_ack,
  output logic       busy,
  output logic [6:0] wiper_pos,
  output logic       err_timeout,
  output logic       dp_cs_n,
  output logic       dp_ud,
  output logic [6:0] pulse_num,
  output logic       pulse_start,
  input  logic       pulse_done
);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, HOLD, STORE} state_t;

  localparam int         CW        = $clog2(TIMEOUT + SETUP_CYC + HOLD_CYC + 1);
  localparam logic [6:0] MAXP      = 7'(MAX_POS);
  localparam bit         HOME      = (HOME_ON_RESET != 0);
  localparam state_t     RST_STATE = HOME ? SETUP : IDLE;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    tgt;
  logic [6:0]    req_tgt;
  logic          req_up;
  logic [6:0]    req_delta;

  assign req_tgt   = (wr_target > MAXP) ? MAXP : wr_target;
  assign req_up    = req_tgt > wiper_pos;
  assign req_delta = req_up ? (req_tgt - wiper_pos) : (wiper_pos - req_tgt);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      // Homing is an ordinary down move of MAX_POS pulses toward position 0.
      state       <= RST_STATE;
      busy        <= HOME;
      cnt         <= '0;
      tgt         <= 7'd0;
      wiper_pos   <= 7'd0;
      err_timeout <= 1'b0;
      dp_cs_n     <= 1'b1;
      dp_ud       <= 1'b0;
      pulse_num   <= HOME ? MAXP : 7'd0;
      pulse_start <= 1'b0;
      wr_ack      <= 1'b0;
    end else begin
      wr_ack      <= 1'b0;
      pulse_start <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            wr_ack      <= 1'b1;
            err_timeout <= 1'b0;
            if (req_delta != 7'd0) begin
              state     <= SETUP;
              busy      <= 1'b1;
              dp_cs_n   <= 1'b0;
              dp_ud     <= req_up;
              pulse_num <= req_delta;
              tgt       <= req_tgt;
              cnt       <= '0;
            end
          end else if (store_req) begin
            wr_ack    <= 1'b1;
            state     <= STORE;
            busy      <= 1'b1;
            dp_cs_n   <= 1'b0;
            pulse_num <= 7'd0;
            cnt       <= '0;
          end
        end
        SETUP: begin
          dp_cs_n <= 1'b0;
          if (cnt == CW'(SETUP_CYC - 1)) begin
            state       <= RUN;
            pulse_start <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (pulse_done) begin
            wiper_pos <= tgt;
            state     <= HOLD;
            cnt       <= '0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            dp_cs_n     <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD, STORE: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            dp_cs_n <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          dp_cs_n <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digpot_ctrl.sv
// Bench for digpot_ctrl: constant vector table, random moves against a
// position/arithmetic model, plus homing, store, timeout and reset sequences.
module tb_digpot_ctrl;
  localparam int MAXP = 99;
  localparam int SC   = 4;
  localparam int HC   = 8;
  localparam int TO   = 4096;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       wr_en, store_req, pulse_done;
  logic [6:0] wr_target;
  logic       wr_ack, busy, err_timeout, dp_cs_n, dp_ud, pulse_start;
  logic [6:0] wiper_pos, pulse_num;

  int total = 0;
  int bad   = 0;
  int m_pos = 0;
  bit pg_en = 1'b1;
  int pg_dly = 10;

  typedef struct {
    logic [6:0] t;
    int         d;
    logic       ud;
    int         num;
    int         pos;
  } vec_t;
  vec_t tbl[7];

  digpot_ctrl #(.MAX_POS(MAXP), .SETUP_CYC(SC), .HOLD_CYC(HC), .TIMEOUT(TO),
                .HOME_ON_RESET(1)) dut (
    .clk_in(clk_in), .reset(reset), .wr_en(wr_en), .wr_target(wr_target),
    .store_req(store_req), .wr_ack(wr_ack), .busy(busy), .wiper_pos(wiper_pos),
    .err_timeout(err_timeout), .dp_cs_n(dp_cs_n), .dp_ud(dp_ud),
    .pulse_num(pulse_num), .pulse_start(pulse_start), .pulse_done(pulse_done));

  always #5 clk_in = ~clk_in;

  // Pulse generator stand-in: pulse_done is sampled pg_dly edges after pulse_start.
  initial begin
    pulse_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (pulse_start && pg_en) begin
        repeat (pg_dly - 1) @(negedge clk_in);
        pulse_done = 1'b1;
        @(negedge clk_in);
        pulse_done = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Observe one busy episode starting at the current negedge (index 0).
  task automatic watch(output int busy_n, output int low_n, output int ps_n,
                       output int ps_idx, output int unstable, output bit hung);
    logic ud0;
    logic [6:0] n0;
    busy_n = 0; low_n = 0; ps_n = 0; ps_idx = -1; unstable = 0; hung = 1'b1;
    ud0 = dp_ud; n0 = pulse_num;
    for (int i = 0; i < 8000; i++) begin
      if (!busy) begin
        hung = 1'b0;
        return;
      end
      if (!dp_cs_n) low_n++;
      if (pulse_start) begin ps_n++; ps_idx = busy_n; end
      if (dp_ud != ud0 || pulse_num != n0 || (busy_n > 0 && wr_ack)) unstable++;
      busy_n++;
      @(negedge clk_in);
    end
  endtask

  task automatic homing_check(input string nm);
    int bn, ln, pn, pi, us; bit hg;
    chk({nm, ".num"}, pulse_num, MAXP);
    chk({nm, ".ud"}, dp_ud, 0);
    chk({nm, ".busy"}, busy, 1);
    pg_en = 1'b1; pg_dly = 10;
    watch(bn, ln, pn, pi, us, hg);
    chk({nm, ".hang"}, hg, 0);
    chk({nm, ".ps_idx"}, pi, SC);
    chk({nm, ".ps_n"}, pn, 1);
    chk({nm, ".busy_cyc"}, bn, SC + 10 + HC);
    // chip select is still released during the first cycle after reset
    chk({nm, ".low_cyc"}, ln, SC + 10 + HC - 1);
    chk({nm, ".stable"}, us, 0);
    chk({nm, ".pos"}, wiper_pos, 0);
    chk({nm, ".cs_end"}, dp_cs_n, 1);
    m_pos = 0;
  endtask

  task automatic write_op(input logic [6:0] t, input int dly, input logic e_ud,
                          input int e_num, input int e_pos, input string nm);
    int bn, ln, pn, pi, us; bit hg;
    pg_dly = dly;
    wr_target = t; wr_en = 1'b1;
    @(negedge clk_in);
    wr_en = 1'b0;
    chk({nm, ".ack"}, wr_ack, 1);
    chk({nm, ".err"}, err_timeout, 0);
    if (e_num == 0) begin
      chk({nm, ".noop_busy"}, busy, 0);
      @(negedge clk_in);
      chk({nm, ".noop_ps"}, pulse_start, 0);
      chk({nm, ".noop_busy2"}, busy, 0);
    end else begin
      chk({nm, ".ud"}, dp_ud, e_ud);
      chk({nm, ".num"}, pulse_num, e_num);
      watch(bn, ln, pn, pi, us, hg);
      chk({nm, ".hang"}, hg, 0);
      chk({nm, ".ps_n"}, pn, 1);
      chk({nm, ".ps_idx"}, pi, SC);
      chk({nm, ".low_cyc"}, ln, SC + dly + HC);
      chk({nm, ".busy_cyc"}, bn, SC + dly + HC);
      chk({nm, ".stable"}, us, 0);
      chk({nm, ".cs_end"}, dp_cs_n, 1);
    end
    chk({nm, ".pos"}, wiper_pos, e_pos);
    m_pos = e_pos;
  endtask

  task automatic store_op(input string nm);
    int bn, ln, pn, pi, us; bit hg;
    store_req = 1'b1;
    @(negedge clk_in);
    store_req = 1'b0;
    chk({nm, ".ack"}, wr_ack, 1);
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".num"}, pulse_num, 0);
    watch(bn, ln, pn, pi, us, hg);
    chk({nm, ".hang"}, hg, 0);
    chk({nm, ".ps_n"}, pn, 0);
    chk({nm, ".cyc"}, bn, HC);
    chk({nm, ".low"}, ln, HC);
    chk({nm, ".stable"}, us, 0);
    chk({nm, ".pos"}, wiper_pos, m_pos);
  endtask

  initial begin
    int bn, ln, pn, pi, us; bit hg, seen;
    logic [6:0] rt; int rd, tg;

    tbl[0] = '{7'd40,  10, 1'b1, 40, 40};
    tbl[1] = '{7'd120,  5, 1'b1, 59, 99};
    tbl[2] = '{7'd10,   7, 1'b0, 89, 10};
    tbl[3] = '{7'd10,   3, 1'b0,  0, 10};
    tbl[4] = '{7'd99,   1, 1'b1, 89, 99};
    tbl[5] = '{7'd0,    2, 1'b0, 99,  0};
    tbl[6] = '{7'd127,  4, 1'b1, 99, 99};

    reset = 1'b1; wr_en = 1'b0; store_req = 1'b0; wr_target = 7'd0;
    #7;
    chk("rst.cs", dp_cs_n, 1);
    chk("rst.ps", pulse_start, 0);
    chk("rst.ack", wr_ack, 0);
    chk("rst.pos", wiper_pos, 0);
    chk("rst.err", err_timeout, 0);
    chk("rst.busy", busy, 1);
    @(negedge clk_in);
    reset = 1'b0;
    homing_check("home");

    for (int i = 0; i < 7; i++)
      write_op(tbl[i].t, tbl[i].d, tbl[i].ud, tbl[i].num, tbl[i].pos,
               $sformatf("vec%0d", i));

    // write and store together: write first, store still held afterwards
    store_req = 1'b1;
    write_op(7'd50, 3, 1'b0, 49, 50, "simul_wr");
    store_op("simul_st");

    // timeout: pulse generator silent
    pg_en = 1'b0;
    wr_target = 7'd70; wr_en = 1'b1;
    @(negedge clk_in);
    wr_en = 1'b0;
    chk("to.ack", wr_ack, 1);
    watch(bn, ln, pn, pi, us, hg);
    chk("to.hang", hg, 0);
    chk("to.cyc", bn, SC + TO);
    chk("to.err", err_timeout, 1);
    chk("to.cs", dp_cs_n, 1);
    chk("to.pos", wiper_pos, 50);
    pg_en = 1'b1;
    @(negedge clk_in);
    chk("to.err_sticky", err_timeout, 1);
    write_op(7'd60, 2, 1'b1, 10, 60, "to.clear");

    for (int i = 0; i < 20; i++) begin
      rt = 7'($urandom_range(0, 127));
      rd = $urandom_range(1, 15);
      tg = (int'(rt) > MAXP) ? MAXP : int'(rt);
      write_op(rt, rd, tg > m_pos, (tg > m_pos) ? tg - m_pos : m_pos - tg, tg,
               $sformatf("rnd%0d", i));
    end

    // reset in the middle of RUN
    pg_en = 1'b0;
    wr_target = (m_pos == 80) ? 7'd20 : 7'd80; wr_en = 1'b1;
    @(negedge clk_in);
    wr_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_in);
      if (pulse_start) seen = 1'b1;
    end
    chk("mid.run", seen, 1);
    repeat (3) @(negedge clk_in);
    #3 reset = 1'b1;
    #1;
    chk("mid.cs", dp_cs_n, 1);
    chk("mid.pos", wiper_pos, 0);
    chk("mid.num", pulse_num, MAXP);
    chk("mid.ud", dp_ud, 0);
    chk("mid.ps", pulse_start, 0);
    @(negedge clk_in);
    reset = 1'b0;
    homing_check("rehome");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digpot_ctrl.md
DIGPOT_CTRL -- requirements
Module: digpot_ctrl

Interface
REQ-001 Parameter MAX_POS, default 99: highest legal wiper position.
REQ-002 Parameter SETUP_CYC, default 4: cycles from chip-select assertion to pulse_start, with direction stable.
REQ-003 Parameter HOLD_CYC, default 8: cycles dp_cs_n stays low after pulse_done, and length of a store cycle.
REQ-004 Parameter TIMEOUT, default 4096: maximum cycles in RUN while waiting for pulse_done.
REQ-005 Parameter HOME_ON_RESET, default 1: 1 = drive wiper to position 0 after reset.
REQ-006 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  level request to move the wiper to wr_target.
REQ-009 wr_target  input  7  requested wiper position.
REQ-010 store_req  input  1  level request to run a nonvolatile store cycle.
REQ-011 wr_ack  output  1  one-cycle pulse when a write or store request is accepted.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 wiper_pos  output  7  tracked wiper position.
REQ-014 err_timeout  output  1  sticky flag; pulse_done was missed.
REQ-015 dp_cs_n  output  1  potentiometer chip select, active low.
REQ-016 dp_ud  output  1  direction to the device; 1 = up, 0 = down.
REQ-017 pulse_num  output  7  pulse count sent to the downstream increment-pulse generator.
REQ-018 pulse_start  output  1  one-cycle launch strobe to the pulse generator.
REQ-019 pulse_done  input  1  one-cycle strobe from the pulse generator when its burst is complete.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, RUN, HOLD and STORE.
REQ-021 In IDLE, an asserted wr_en SHALL be accepted, with wr_ack high on the next cycle.
- Target is clamped: tgt = min(wr_target, MAX_POS).
- If tgt == wiper_pos, the FSM stays in IDLE.
- Otherwise the FSM goes to SETUP with dp_ud = (tgt > wiper_pos) and pulse_num = |tgt - wiper_pos|.
REQ-022 In IDLE with store_req high and wr_en low, the request SHALL be accepted (wr_ack pulse) and the FSM SHALL go to STORE.
REQ-023 If wr_en and store_req are high together in IDLE, the write SHALL win; store_req stays pending if it is still held.
REQ-024 Requests arriving outside IDLE SHALL be ignored, not queued, with no wr_ack; the requester holds the level until wr_ack.
REQ-025 SETUP: dp_cs_n = 0 for exactly SETUP_CYC cycles, then pulse_start = 1 for one cycle on entry to RUN.
REQ-026 dp_ud and pulse_num SHALL stay constant from SETUP entry until HOLD exit.
REQ-027 RUN: on pulse_done, wiper_pos SHALL update to tgt and the FSM SHALL go to HOLD.
- A pulse_done seen in any other state SHALL be ignored.
REQ-028 RUN: if TIMEOUT cycles elapse without pulse_done, the FSM SHALL:
- set err_timeout;
- leave wiper_pos unchanged;
- force dp_cs_n = 1;
- go to IDLE.
REQ-029 err_timeout SHALL clear on the next accepted write.
REQ-030 HOLD: dp_cs_n = 0 for HOLD_CYC cycles, then dp_cs_n = 1 and the FSM goes to IDLE.
REQ-031 STORE: pulse_num = 0 and no pulse_start; dp_cs_n = 0 for HOLD_CYC cycles, then 1, then IDLE.
REQ-032 busy SHALL equal (state != IDLE), registered together with the state.
REQ-033 All arithmetic is 7-bit unsigned; the delta never exceeds MAX_POS, so no wrap-around occurs.

Reset
REQ-034 On reset assertion, without waiting for a clock edge, the block SHALL force:
- dp_cs_n = 1, dp_ud = 0, pulse_num = 0;
- pulse_start = 0, wr_ack = 0;
- wiper_pos = 0, err_timeout = 0.
REQ-035 Reset with HOME_ON_RESET = 1 SHALL enter SETUP with busy = 1, dp_ud = 0 and pulse_num = MAX_POS.
- The homing move then runs the normal sequence and ends with wiper_pos = 0.
REQ-036 Reset with HOME_ON_RESET = 0 SHALL enter IDLE with busy = 0.
REQ-037 Reset asserted mid-operation SHALL abort the current operation immediately, with the REQ-034 values.

Verification
REQ-038 Homing: release reset with pulse_done returned 10 cycles after pulse_start.
- Required: pulse_num = 99, dp_ud = 0.
- pulse_start comes SETUP_CYC cycles after reset release.
- wiper_pos = 0 and busy = 0 after HOLD_CYC.
REQ-039 Up move: wiper_pos = 0, wr_target = 40.
- Required: wr_ack, dp_ud = 1, pulse_num = 40, one pulse_start.
- On pulse_done, wiper_pos = 40.
- dp_cs_n is low for exactly SETUP_CYC + RUN + HOLD_CYC cycles.
REQ-040 Clamp and down move:
- From 40, wr_target = 120 -> pulse_num = 59, dp_ud = 1, wiper_pos = 99.
- Then wr_target = 10 -> pulse_num = 89, dp_ud = 0.
REQ-041 No-op and simultaneous requests:
- wr_target equal to wiper_pos -> wr_ack, busy stays 0, no pulse_start.
- wr_en and store_req together -> write first, then store with no pulse_start.
REQ-042 Timeout: pulse_done is never returned.
- Required: err_timeout = 1 after TIMEOUT cycles, dp_cs_n = 1, wiper_pos unchanged.
- The next accepted write clears err_timeout.
REQ-043 Reset mid-RUN: assert reset between edges.
- Required: dp_cs_n = 1 immediately.
- After release, homing per REQ-038.
